// File: rtl/pipe_pkg.sv
// Shared definitions for valid/ready pipeline stages.
// Contents:
//   WB_REGWRITE / WB_MEMTOREG  bit positions inside the write-back control field
//   CNT_EMPTY / CNT_ONE / CNT_TWO  occupancy encodings reported on count outputs
//   skid_state_e               two-entry skid buffer state, encoded as its occupancy
//   memwb_payload_t            reference payload layout at the default MEM/WB widths
package pipe_pkg;

   localparam int unsigned WB_REGWRITE = 0;
   localparam int unsigned WB_MEMTOREG = 1;

   localparam logic [1:0] CNT_EMPTY = 2'd0;
   localparam logic [1:0] CNT_ONE   = 2'd1;
   localparam logic [1:0] CNT_TWO   = 2'd2;

   localparam int unsigned DEF_DATA_W = 32;
   localparam int unsigned DEF_ADDR_W = 5;
   localparam int unsigned DEF_CTRL_W = 2;

   // State codes equal the occupancy so the count output is the state register itself.
   typedef enum logic [1:0] {
      StEmpty = CNT_EMPTY,
      StOne   = CNT_ONE,
      StTwo   = CNT_TWO
   } skid_state_e;

   // Field order {ctrl, memdata, regdata, regaddr}; stages with other widths declare
   // the same layout locally from their own parameters.
   typedef struct packed {
      logic [DEF_CTRL_W-1:0] ctrl;
      logic [DEF_DATA_W-1:0] memdata;
      logic [DEF_DATA_W-1:0] regdata;
      logic [DEF_ADDR_W-1:0] regaddr;
   } memwb_payload_t;

endpackage

// File: rtl/memwb_skid_stage_if.sv
// Bundle of handshake, control and payload signals around the MEM/WB skid stage.
// Modports:
//   slave  - the stage itself: takes upstream payload/valid and downstream ready,
//            drives in_ready_o, head outputs and count_o
//   master - the environment driving the stage (MEM stage plus write-back consumer)
interface memwb_skid_stage_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned CTRL_W = 2
) ();

   logic              flush_i;
   logic              in_valid_i;
   logic              in_ready_o;
   logic [CTRL_W-1:0] WB_i;
   logic [DATA_W-1:0] MemData_i;
   logic [DATA_W-1:0] RegData_i;
   logic [ADDR_W-1:0] RegAddr_i;

   logic              out_valid_o;
   logic              out_ready_i;
   logic              RegWrite_o;
   logic              MemtoReg_o;
   logic [CTRL_W-1:0] ctrl_o;
   logic [DATA_W-1:0] MemData_o;
   logic [DATA_W-1:0] RegData_o;
   logic [ADDR_W-1:0] RegAddr_o;
   logic [DATA_W-1:0] WBData_o;
   logic [1:0]        count_o;

   modport slave (
      input  flush_i, in_valid_i, WB_i, MemData_i, RegData_i, RegAddr_i, out_ready_i,
      output in_ready_o, out_valid_o, RegWrite_o, MemtoReg_o, ctrl_o, MemData_o,
             RegData_o, RegAddr_o, WBData_o, count_o
   );

   modport master (
      output flush_i, in_valid_i, WB_i, MemData_i, RegData_i, RegAddr_i, out_ready_i,
      input  in_ready_o, out_valid_o, RegWrite_o, MemtoReg_o, ctrl_o, MemData_o,
             RegData_o, RegAddr_o, WBData_o, count_o
   );

endinterface

// File: rtl/pipe_skid_buf.sv
// Generic two-entry valid/ready skid buffer, strictly FIFO.
// Ports:
//   clk_i, rst_i         clock, asynchronous active-high reset
//   flush_i              synchronous drop of both entries (beats a simultaneous input)
//   in_valid_i/in_ready_o/in_data_i     upstream side; in_ready_o is registered
//   out_valid_o/out_ready_i/out_data_o  downstream side; out_data_o is the head register
//   count_o              entries held, 0..2
module pipe_skid_buf
   import pipe_pkg::*;
#(
   parameter int unsigned PAYLOAD_W = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 flush_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [PAYLOAD_W-1:0] in_data_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [PAYLOAD_W-1:0] out_data_o,
   output logic [1:0]           count_o
);

   skid_state_e          state_q, state_d;
   logic [PAYLOAD_W-1:0] head_q, head_d;
   logic [PAYLOAD_W-1:0] skid_q, skid_d;
   logic                 in_xfer, out_xfer;

   // Both handshake flags come from state_q only, so out_ready_i never reaches in_ready_o.
   assign in_ready_o  = (state_q != StTwo);
   assign out_valid_o = (state_q != StEmpty);
   assign out_data_o  = head_q;
   assign count_o     = state_q;

   assign in_xfer  = in_valid_i & in_ready_o;
   assign out_xfer = out_valid_o & out_ready_i;

   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      skid_d  = skid_q;
      if (flush_i) begin
         // Payload registers keep their contents; only occupancy is cleared.
         state_d = StEmpty;
      end else begin
         unique case (state_q)
            StEmpty: begin
               if (in_xfer) begin
                  head_d  = in_data_i;
                  state_d = StOne;
               end
            end
            StOne: begin
               if (in_xfer && out_xfer) begin
                  head_d = in_data_i;
               end else if (in_xfer) begin
                  skid_d  = in_data_i;
                  state_d = StTwo;
               end else if (out_xfer) begin
                  state_d = StEmpty;
               end
            end
            StTwo: begin
               if (out_xfer) begin
                  head_d  = skid_q;
                  state_d = StOne;
               end
            end
            default: state_d = StEmpty;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= StEmpty;
         head_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         skid_q  <= skid_d;
      end
   end

endmodule

// File: rtl/memwb_skid_stage.sv
// MEM/WB pipeline stage with a two-entry skid buffer and valid/ready on both sides.
// Ports:
//   clk_i  clock, rising edge
//   rst_i  asynchronous active-high reset; clears occupancy and all payload/outputs
//   bus    memwb_skid_stage_if.slave: flush, upstream handshake + WB/MemData/RegData/
//          RegAddr payload, downstream handshake, head fields, WBData mux, count
// GATE_WE = 1 forces RegWrite_o low whenever no valid head is present.
module memwb_skid_stage
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned ADDR_W  = 5,
   parameter int unsigned CTRL_W  = 2,
   parameter bit          GATE_WE = 1'b1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   memwb_skid_stage_if.slave   bus
);

   typedef struct packed {
      logic [CTRL_W-1:0] ctrl;
      logic [DATA_W-1:0] memdata;
      logic [DATA_W-1:0] regdata;
      logic [ADDR_W-1:0] regaddr;
   } payload_t;

   localparam int unsigned PAYLOAD_W = $bits(payload_t);

   payload_t in_pl;
   payload_t head;
   logic     head_valid;

   assign in_pl.ctrl    = bus.WB_i;
   assign in_pl.memdata = bus.MemData_i;
   assign in_pl.regdata = bus.RegData_i;
   assign in_pl.regaddr = bus.RegAddr_i;

   pipe_skid_buf #(
      .PAYLOAD_W (PAYLOAD_W)
   ) u_skid_buf (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .flush_i     (bus.flush_i),
      .in_valid_i  (bus.in_valid_i),
      .in_ready_o  (bus.in_ready_o),
      .in_data_i   (in_pl),
      .out_valid_o (head_valid),
      .out_ready_i (bus.out_ready_i),
      .out_data_o  (head),
      .count_o     (bus.count_o)
   );

   assign bus.out_valid_o = head_valid;
   assign bus.ctrl_o      = head.ctrl;
   assign bus.MemData_o   = head.memdata;
   assign bus.RegData_o   = head.regdata;
   assign bus.RegAddr_o   = head.regaddr;
   assign bus.MemtoReg_o  = head.ctrl[WB_MEMTOREG];
   assign bus.RegWrite_o  = GATE_WE ? (head.ctrl[WB_REGWRITE] & head_valid)
                                    : head.ctrl[WB_REGWRITE];
   assign bus.WBData_o    = head.ctrl[WB_MEMTOREG] ? head.memdata : head.regdata;

endmodule

// File: tb/tb_memwb_skid_stage.sv
// Drives a 32-bit (gated) and a 64-bit (ungated) stage with identical handshakes and
// compares both against a queue model of a two-deep FIFO.
module tb_memwb_skid_stage;

   typedef struct packed {
      logic [3:0]  ctrl;
      logic [63:0] mem;
      logic [63:0] rd;
      logic [5:0]  addr;
   } ent_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   memwb_skid_stage_if #(.DATA_W(32), .ADDR_W(5), .CTRL_W(2)) b32 ();
   memwb_skid_stage_if #(.DATA_W(64), .ADDR_W(6), .CTRL_W(4)) b64 ();

   memwb_skid_stage #(.DATA_W(32), .ADDR_W(5), .CTRL_W(2), .GATE_WE(1'b1)) dut32 (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (b32.slave)
   );

   memwb_skid_stage #(.DATA_W(64), .ADDR_W(6), .CTRL_W(4), .GATE_WE(1'b0)) dut64 (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (b64.slave)
   );

   int   n_cmp = 0;
   int   n_bad = 0;
   ent_t q[$];
   ent_t last_head;
   logic drv_v, drv_ordy, drv_flush, held;
   ent_t drv_e;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, want, $time);
      end
   endtask

   task automatic apply();
      b32.in_valid_i  = drv_v;
      b32.WB_i        = drv_e.ctrl[1:0];
      b32.MemData_i   = drv_e.mem[31:0];
      b32.RegData_i   = drv_e.rd[31:0];
      b32.RegAddr_i   = drv_e.addr[4:0];
      b32.out_ready_i = drv_ordy;
      b32.flush_i     = drv_flush;
      b64.in_valid_i  = drv_v;
      b64.WB_i        = drv_e.ctrl;
      b64.MemData_i   = drv_e.mem;
      b64.RegData_i   = drv_e.rd;
      b64.RegAddr_i   = drv_e.addr;
      b64.out_ready_i = drv_ordy;
      b64.flush_i     = drv_flush;
   endtask

   task automatic compare_all();
      ent_t h;
      int   n;
      n = q.size();
      check_val("in_ready32", 64'(b32.in_ready_o), 64'(n < 2));
      check_val("in_ready64", 64'(b64.in_ready_o), 64'(n < 2));
      check_val("out_valid32", 64'(b32.out_valid_o), 64'(n > 0));
      check_val("out_valid64", 64'(b64.out_valid_o), 64'(n > 0));
      check_val("count32", 64'(b32.count_o), 64'(n));
      check_val("count64", 64'(b64.count_o), 64'(n));
      check_val("we64_ungated", 64'(b64.RegWrite_o), 64'(last_head.ctrl[0]));
      if (n > 0) begin
         h = q[0];
         check_val("ctrl32", 64'(b32.ctrl_o), 64'(h.ctrl[1:0]));
         check_val("regdata32", 64'(b32.RegData_o), 64'(h.rd[31:0]));
         check_val("memdata32", 64'(b32.MemData_o), 64'(h.mem[31:0]));
         check_val("regaddr32", 64'(b32.RegAddr_o), 64'(h.addr[4:0]));
         check_val("we32", 64'(b32.RegWrite_o), 64'(h.ctrl[0]));
         check_val("m2r32", 64'(b32.MemtoReg_o), 64'(h.ctrl[1]));
         check_val("wbdata32", 64'(b32.WBData_o), 64'(h.ctrl[1] ? h.mem[31:0] : h.rd[31:0]));
         check_val("ctrl64", 64'(b64.ctrl_o), 64'(h.ctrl));
         check_val("regdata64", b64.RegData_o, h.rd);
         check_val("memdata64", b64.MemData_o, h.mem);
         check_val("regaddr64", 64'(b64.RegAddr_o), 64'(h.addr));
         check_val("wbdata64", b64.WBData_o, h.ctrl[1] ? h.mem : h.rd);
      end else begin
         check_val("we32_gated", 64'(b32.RegWrite_o), 64'd0);
      end
   endtask

   // One clock: inputs set at the previous negedge take effect at this posedge.
   task automatic step();
      bit rdy, vld;
      rdy = (q.size() < 2);
      vld = (q.size() > 0);
      held = drv_v && !rdy;
      @(posedge clk);
      if (drv_flush) begin
         q.delete();
      end else begin
         if (vld && drv_ordy) void'(q.pop_front());
         if (drv_v && rdy) q.push_back(drv_e);
      end
      if (q.size() > 0) last_head = q[0];
      @(negedge clk);
      compare_all();
   endtask

   task automatic check_zero_outputs(input string tag);
      check_val({tag, "_wbdata32"}, 64'(b32.WBData_o), 64'd0);
      check_val({tag, "_regaddr32"}, 64'(b32.RegAddr_o), 64'd0);
      check_val({tag, "_we32"}, 64'(b32.RegWrite_o), 64'd0);
      check_val({tag, "_m2r32"}, 64'(b32.MemtoReg_o), 64'd0);
      check_val({tag, "_valid32"}, 64'(b32.out_valid_o), 64'd0);
      check_val({tag, "_ready32"}, 64'(b32.in_ready_o), 64'd1);
      check_val({tag, "_wbdata64"}, b64.WBData_o, 64'd0);
      check_val({tag, "_ctrl64"}, 64'(b64.ctrl_o), 64'd0);
      check_val({tag, "_count64"}, 64'(b64.count_o), 64'd0);
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      drv_v     = 1'b0;
      drv_ordy  = 1'b0;
      drv_flush = 1'b0;
      drv_e     = '0;
      held      = 1'b0;
      apply();
      q.delete();
      last_head = '0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      compare_all();
      check_zero_outputs("reset");
   endtask

   task automatic send(input logic [3:0] c, input logic [63:0] m, input logic [63:0] r,
                       input logic [5:0] a, input logic ordy);
      drv_v    = 1'b1;
      drv_e    = '{ctrl: c, mem: m, rd: r, addr: a};
      drv_ordy = ordy;
      apply();
      step();
   endtask

   task automatic idle(input logic ordy, input int cycles);
      drv_v    = 1'b0;
      drv_ordy = ordy;
      apply();
      for (int i = 0; i < cycles; i++) step();
   endtask

   // Upstream obligation: payload stable while offered and not accepted.
   logic [141:0] prev_pl;
   logic         prev_hold = 1'b0;
   always @(posedge clk) begin
      if (!rst && prev_hold && b64.in_valid_i)
         assert ({b64.WB_i, b64.MemData_i, b64.RegData_i, b64.RegAddr_i} == prev_pl)
         else $error("FAIL protocol: payload changed while stalled");
      prev_hold <= b64.in_valid_i && !b64.in_ready_o;
      prev_pl   <= {b64.WB_i, b64.MemData_i, b64.RegData_i, b64.RegAddr_i};
   end

   initial begin
      do_reset();

      // Single transfer with one-cycle latency.
      send(4'b0001, 64'h0, 64'hAA, 6'd5, 1'b1);
      check_val("t1_valid", 64'(b32.out_valid_o), 64'd1);
      check_val("t1_we", 64'(b32.RegWrite_o), 64'd1);
      check_val("t1_wbdata", 64'(b32.WBData_o), 64'hAA);
      check_val("t1_addr", 64'(b32.RegAddr_o), 64'd5);
      check_val("t1_count", 64'(b32.count_o), 64'd1);
      idle(1'b1, 2);

      // Back-to-back streaming with 64-bit patterns.
      for (int i = 1; i <= 8; i++) begin
         send(4'b1000 | 4'(i & 1), {32'hA5A5_0000, 32'(i)}, {32'hC3C3_0000, 32'(i)},
              6'(i), 1'b1);
         check_val("t2_regdata", 64'(b32.RegData_o), 64'(i));
      end
      idle(1'b1, 2);

      // Backpressure fill: A, B held, C refused until space opens.
      send(4'b0101, 64'h0, 64'hF000_0000_0000_0011, 6'd1, 1'b0);
      send(4'b0101, 64'h0, 64'hF000_0000_0000_0022, 6'd2, 1'b0);
      send(4'b0101, 64'h0, 64'hF000_0000_0000_0033, 6'd3, 1'b0);
      step();
      check_val("t3_count", 64'(b32.count_o), 64'd2);
      check_val("t3_hold_a", 64'(b32.WBData_o), 64'h11);
      check_val("t3_ready", 64'(b32.in_ready_o), 64'd0);
      drv_ordy = 1'b1;
      apply();
      step();
      check_val("t3_order_b", 64'(b32.RegData_o), 64'h22);
      step();
      check_val("t3_order_c", b64.RegData_o, 64'hF000_0000_0000_0033);
      idle(1'b1, 2);

      // Flush while full with a simultaneous offered input.
      send(4'b0011, 64'h1, 64'h2, 6'd7, 1'b0);
      send(4'b0011, 64'h3, 64'h4, 6'd8, 1'b0);
      drv_flush = 1'b1;
      send(4'b0011, 64'h5, 64'h6, 6'd9, 1'b0);
      drv_flush = 1'b0;
      drv_v     = 1'b0;
      apply();
      check_val("t4_valid", 64'(b32.out_valid_o), 64'd0);
      check_val("t4_count", 64'(b32.count_o), 64'd0);
      check_val("t4_we_gated", 64'(b32.RegWrite_o), 64'd0);
      check_val("t4_ready", 64'(b32.in_ready_o), 64'd1);
      idle(1'b1, 1);

      // Load select, then asynchronous reset between edges.
      send(4'b0011, 64'h0000_0000_DEAD_BEEF, 64'h1234, 6'd3, 1'b0);
      drv_v = 1'b0;
      apply();
      check_val("t5_wbdata_mem", 64'(b32.WBData_o), 64'hDEAD_BEEF);
      #2;
      rst = 1'b1;
      #1;
      check_zero_outputs("async_rst");
      q.delete();
      last_head = '0;
      @(negedge clk);
      rst = 1'b0;
      compare_all();

      // Randomized traffic on both widths.
      held = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (!held) begin
            drv_v = ($urandom_range(0, 3) != 0);
            drv_e = '{ctrl: 4'($urandom), mem: {$urandom, $urandom}, rd: {$urandom, $urandom},
                      addr: 6'($urandom)};
         end
         drv_ordy  = ($urandom_range(0, 2) != 0);
         drv_flush = ($urandom_range(0, 31) == 0);
         apply();
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
